// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - state encoding and counter sizing for the bit-serial adder
package serial_adder_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_t;

   // Bit-position counter width; a 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int w);
      int c;
      c = $clog2(w);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - sequences one full_adder cell LSB-first across WIDTH cycles
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   import serial_adder_ctrl_pkg::*;

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_s_next;

   full_adder u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .cout (w_fa_cout)
   );

   // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   assign w_s_next = WIDTH'({w_fa_sum, r_s_sh} >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_state <= S_SHIFT;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_s_sh  <= w_s_next;
               r_carry <= w_fa_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_sum   <= w_s_next;
                  r_cout  <= w_fa_cout;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign sum   = r_sum;
   assign cout  = r_cout;

endmodule
